// File: rtl/card_shoe.sv
// card_shoe: single-deck blackjack card shoe.
// Ten rank bins (values 2..11) are drawn from by a free-running LFSR start
// pointer that walks forward to the first non-empty bin.
// Optional feature: define CARD_SHOE_CUT_EN to reshuffle once cards_left
// drops to CUT_LEVEL or below (casino cut card) instead of at empty.
module card_shoe #(
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         CUT_LEVEL = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       shuffle,
  output logic [3:0] card,
  output logic [3:0] prev_card,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       shuffled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    SEARCH  = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] start_bin;
  logic [4:0] cnt_q [10];
  logic [4:0] cnt_d [10];
  logic [5:0] left_q, left_d;
  logic       shuf_pend_q, shuf_pend_d;
  logic       req_pend_q, req_pend_d;
  logic [3:0] card_q, card_d;
  logic [3:0] prev_q, prev_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       shuffled_q, shuffled_d;
  logic       need_reload;
  logic       bin_hit;

  // Bin 8 (value 10) holds ten/J/Q/K; every other rank holds four cards.
  function automatic logic [4:0] full_count(input int unsigned b);
    return (b == 32'd8) ? 5'd16 : 5'd4;
  endfunction

  // LFSR feedback, start-bin folding and reload condition.
  always_comb begin
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    start_bin = (lfsr_q[3:0] < 4'd10) ? lfsr_q[3:0] : (lfsr_q[3:0] - 4'd6);
    bin_hit   = (cnt_q[ptr_q] != 5'd0);
`ifdef CARD_SHOE_CUT_EN
    need_reload = (left_q <= 6'(CUT_LEVEL));
`else
    need_reload = (left_q == 6'd0);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control: pending flags and bin pointer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    req_pend_d = req_pend_q;
    // A shuffle arriving in any state is remembered; SHUFFLE consumes it.
    shuf_pend_d = (state_q == SHUFFLE) ? shuffle : (shuf_pend_q | shuffle);
    case (state_q)
      IDLE: begin
        // Shuffle input is honoured the same cycle so shuffle+req reloads first.
        if (shuffle || shuf_pend_q) begin
          state_d    = SHUFFLE;
          req_pend_d = req;
        end else if (req) begin
          if (need_reload) begin
            state_d    = SHUFFLE;
            req_pend_d = 1'b1;
          end else begin
            ptr_d   = start_bin;
            state_d = SEARCH;
          end
        end
      end
      SHUFFLE: begin
        req_pend_d = 1'b0;
        if (req_pend_q) begin
          ptr_d   = start_bin;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (bin_hit) begin
          state_d = DELIVER;
        end else begin
          ptr_d = (ptr_q == 4'd9) ? 4'd0 : (ptr_q + 4'd1);
        end
      end
      DELIVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath next values (counters, cards, pulses).
  always_comb begin
    card_d     = card_q;
    prev_d     = prev_q;
    valid_d    = 1'b0;
    shuffled_d = 1'b0;
    busy_d     = (state_d != IDLE);
    cnt_d      = cnt_q;
    left_d     = left_q;
    case (state_q)
      SHUFFLE: begin
        for (int unsigned b = 0; b < 10; b++) begin
          cnt_d[b] = full_count(b);
        end
        left_d     = 6'd52;
        shuffled_d = 1'b1;
      end
      SEARCH: begin
        if (bin_hit) begin
          cnt_d[ptr_q] = cnt_q[ptr_q] - 5'd1;
          left_d       = left_q - 6'd1;
        end
      end
      DELIVER: begin
        prev_d  = card_q;
        card_d  = ptr_q + 4'd2;
        valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q      <= SEED;
      ptr_q       <= '0;
      left_q      <= 6'd52;
      shuf_pend_q <= 1'b0;
      req_pend_q  <= 1'b0;
      card_q      <= '0;
      prev_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      shuffled_q  <= 1'b0;
      for (int unsigned b = 0; b < 10; b++) begin
        cnt_q[b] <= full_count(b);
      end
    end else begin
      lfsr_q      <= lfsr_d;
      ptr_q       <= ptr_d;
      left_q      <= left_d;
      shuf_pend_q <= shuf_pend_d;
      req_pend_q  <= req_pend_d;
      card_q      <= card_d;
      prev_q      <= prev_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      shuffled_q  <= shuffled_d;
      for (int unsigned b = 0; b < 10; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign card       = card_q;
  assign prev_card  = prev_q;
  assign card_valid = valid_q;
  assign busy       = busy_q;
  assign cards_left = left_q;
  assign shuffled   = shuffled_q;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: stimulus pushes expected draw results,
// a negedge monitor pops them whenever card_valid is seen.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset, req, shuffle;
  logic [3:0] card, prev_card;
  logic       card_valid, busy, shuffled;
  logic [5:0] cards_left;

  card_shoe #(.SEED(8'hA5), .CUT_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .req(req), .shuffle(shuffle),
    .card(card), .prev_card(prev_card), .card_valid(card_valid),
    .busy(busy), .cards_left(cards_left), .shuffled(shuffled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int req_cyc;
    int lat_min;
    int lat_max;
    int left;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   valid_cnt = 0, shuf_cnt = 0, sum = 0, last_card = 0;
  int   hist [16];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pops one expectation per card_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_card = 0;
    end else begin
      if (shuffled) shuf_cnt++;
      if (card_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_card_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("cards_left_at_valid", int'(cards_left), e.left);
          chk_rng("latency", cyc - e.req_cyc, e.lat_min, e.lat_max);
          chk("prev_card", int'(prev_card), last_card);
          chk_rng("card_value", int'(card), 2, 11);
          hist[card]++;
          sum += int'(card);
          last_card = int'(card);
        end
      end
    end
  end

  task automatic push_exp(input int lmin, input int lmax, input int left);
    exp_t e;
    e.req_cyc = cyc + 1;
    e.lat_min = lmin;
    e.lat_max = lmax;
    e.left    = left;
    exp_q.push_back(e);
  endtask

  // One req pulse (optionally with shuffle), then idle so a draw spans 16 cycles.
  task automatic draw(input int lmin, input int lmax, input int left, input logic with_shuf);
    @(posedge clk); #1;
    req = 1'b1;
    shuffle = with_shuf;
    push_exp(lmin, lmax, left);
    @(posedge clk); #1;
    req = 1'b0;
    shuffle = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  initial begin
    int v0, s0, x;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    reset = 1'b1; req = 1'b0; shuffle = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_card", int'(card), 0);
    chk("reset_prev_card", int'(prev_card), 0);
    chk("reset_card_valid", int'(card_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_shuffled", int'(shuffled), 0);
    chk("reset_cards_left", int'(cards_left), 52);
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef CARD_SHOE_CUT_EN
    for (int i = 0; i < 40; i++) draw(2, 11, 51 - i, 1'b0);
    chk("cut_left_after_40", int'(cards_left), 12);
    s0 = shuf_cnt;
    draw(3, 3, 51, 1'b0);
    chk("cut_shuffle_count", shuf_cnt - s0, 1);
`else
    for (int i = 0; i < 16; i++) hist[i] = 0;
    sum = 0;
    v0 = valid_cnt;
    for (int i = 0; i < 52; i++) draw(2, 11, 51 - i, 1'b0);
    chk("deck_valid_count", valid_cnt - v0, 52);
    for (int v = 2; v <= 11; v++) chk($sformatf("hist_value_%0d", v), hist[v], (v == 10) ? 16 : 4);
    chk("deck_sum", sum, 380);
    chk("deck_empty_left", int'(cards_left), 0);
    s0 = shuf_cnt;
    draw(3, 3, 51, 1'b0);
    chk("empty_reshuffle_count", shuf_cnt - s0, 1);
    chk("empty_reshuffle_left", int'(cards_left), 51);
`endif

    // Second req one cycle after the first is dropped.
    v0 = valid_cnt;
    @(posedge clk); #1;
    req = 1'b1;
    push_exp(2, 11, 50);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (16) @(posedge clk);
    chk("double_req_valid_count", valid_cnt - v0, 1);
    chk("double_req_left", int'(cards_left), 50);

    // Pending shuffle with no req reloads without a card.
    v0 = valid_cnt; s0 = shuf_cnt;
    @(posedge clk); #1;
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    repeat (6) @(posedge clk);
    chk("shuffle_only_left", int'(cards_left), 52);
    chk("shuffle_only_count", shuf_cnt - s0, 1);
    chk("shuffle_only_no_valid", valid_cnt - v0, 0);

    // Shuffle and req together: reload then draw, valid 3 cycles after req.
    s0 = shuf_cnt;
    draw(3, 3, 51, 1'b1);
    chk("shuffle_req_count", shuf_cnt - s0, 1);

    // Shuffle during a draw: draw completes first, reload afterwards.
    s0 = shuf_cnt;
    @(posedge clk); #1;
    req = 1'b1;
    push_exp(2, 11, 50);
    @(posedge clk); #1;
    req = 1'b0;
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    repeat (14) @(posedge clk);
    chk("mid_draw_shuffle_left", int'(cards_left), 52);
    chk("mid_draw_shuffle_count", shuf_cnt - s0, 1);

    // Two draws X then Y: card holds Y and prev_card holds X.
    draw(2, 11, 51, 1'b0);
    x = last_card;
    draw(2, 11, 50, 1'b0);
    @(negedge clk);
    chk("xy_card", int'(card), last_card);
    chk("xy_prev_card", int'(prev_card), x);

    // Reset during SEARCH aborts the draw.
    v0 = valid_cnt;
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("search_busy_before_reset", int'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_left", int'(cards_left), 52);
    chk("abort_card_valid", int'(card_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (16) @(posedge clk);
    chk("abort_no_valid", valid_cnt - v0, 0);

    // First draw after reset sees prev_card cleared to 0.
    draw(2, 11, 51, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 The module SHALL have parameter SEED, default 8'hA5, which is the non-zero LFSR reset value.
REQ-002 The module SHALL have parameter CUT_LEVEL, default 12, which is the reshuffle threshold on cards_left when CARD_SHOE_CUT_EN is defined.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port req, input, 1 bit: draw request, a single-cycle pulse from the game FSM's hit path.
REQ-006 The module SHALL have port shuffle, input, 1 bit: forced reshuffle request pulse.
REQ-007 The module SHALL have port card, output, 4 bits: the last dealt card value, 2..11 (11 = ace, 10 = ten/J/Q/K).
REQ-008 The module SHALL have port prev_card, output, 4 bits: the value dealt before card.
REQ-009 The module SHALL have port card_valid, output, 1 bit: a one-cycle pulse when card is updated.
REQ-010 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The module SHALL have port cards_left, output, 6 bits: the number of undealt cards in the shoe, 0..52.
REQ-012 The module SHALL have port shuffled, output, 1 bit: a one-cycle pulse on the cycle the deck is reloaded.

Function
REQ-013 The shoe SHALL hold 10 rank counters, indexed bin 0..9, where bin b maps to card value b+2; bins 0..7 and 9 each hold 4 cards and bin 8 holds 16 cards, for 52 cards in total.
REQ-014 An 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1 SHALL advance every clock; its low nibble n SHALL give start bin n when n<10 and n-6 otherwise.
REQ-015 The FSM SHALL have the states IDLE, SHUFFLE, SEARCH and DELIVER; all outputs SHALL be registered.
REQ-016 In IDLE, on req=1 (or a pending shuffle), the FSM SHALL go to SHUFFLE if a shuffle is pending or cards_left==0; otherwise it SHALL load the bin pointer with the start bin and go to SEARCH.
REQ-017 SHUFFLE SHALL last exactly one cycle: it reloads all counters, sets cards_left=52, pulses shuffled and clears the pending shuffle; it then goes to SEARCH if a req is pending, otherwise to IDLE.
REQ-018 In SEARCH, if count[ptr]!=0 the block SHALL decrement count[ptr] and cards_left and go to DELIVER; otherwise it SHALL set ptr=ptr+1 (9 wraps to 0) and stay in SEARCH.
REQ-019 In DELIVER, the block SHALL set prev_card<=card, card<=ptr+2 and card_valid=1 for one cycle, then return to IDLE.
REQ-020 Latency from req to card_valid SHALL be 2 cycles minimum; a draw SHALL take at most 11 cycles without a shuffle and 12 cycles with one.
REQ-021 A req received while busy=1 SHALL be dropped.
REQ-022 A shuffle received in any state SHALL set the pending-shuffle flag, and the reload SHALL happen on the next IDLE cycle; an in-progress draw SHALL complete first.
REQ-023 When shuffle and req are both high in IDLE, the block SHALL reshuffle first and then draw, with card_valid 3 cycles after req.
REQ-024 A pending shuffle with no req SHALL perform SHUFFLE and return to IDLE without asserting card_valid.
REQ-025 cards_left SHALL never underflow, because a draw only occurs after the empty check.

Reset
REQ-026 On reset, the block SHALL set card=0, prev_card=0, card_valid=0, busy=0, shuffled=0, cards_left=52, all counters full, pending flags clear, LFSR=SEED and state=IDLE.
REQ-027 Reset SHALL take priority over all inputs; reset asserted mid-draw SHALL abort the draw with no card_valid, and the counters SHALL reload.

Configuration
REQ-028 With macro CARD_SHOE_CUT_EN defined, the IDLE check of REQ-016 SHALL use cards_left<=CUT_LEVEL instead of cards_left==0, modelling the casino cut card.
REQ-029 With CARD_SHOE_CUT_EN undefined, the shoe SHALL be dealt down to 0 before it auto-reshuffles, and the CUT_LEVEL parameter SHALL be unused.

Verification
REQ-030 Reset, then 52 reqs spaced 16 cycles apart: the bench SHALL see 52 card_valid pulses, values 2..9 and 11 four times each, value 10 sixteen times, the card sum equal to 380, and a final cards_left of 0.
REQ-031 A 53rd req after REQ-030: the bench SHALL see a shuffled pulse, card_valid 3 cycles after req, and cards_left=51.
REQ-032 A req followed by a second req 1 cycle later: the bench SHALL see exactly one card_valid and cards_left decrement by 1.
REQ-033 Two draws with values X then Y: after the second card_valid, the bench SHALL see card=Y and prev_card=X.
REQ-034 Reset asserted during SEARCH: on the next cycle the bench SHALL see busy=0 and cards_left=52, with no card_valid.
REQ-035 With CARD_SHOE_CUT_EN defined, 40 draws then 1 req: the bench SHALL see shuffled asserted before card_valid and cards_left=51 afterwards.
